a23_copro15_v2: RTL and testbench
=================================

# a23_copro15_v2

Parametrised successor to the Amber 23 CP15 system-control coprocessor. It holds cache control and per-region attribute registers with a configurable region count and granularity. It adds a registered region-attribute lookup port, a handshaked multi-cycle cache flush, and a FIFO fault log in place of a single latched fault. It sits beside the execute stage, driven by MCR/MRC decode, and feeds the cache and fetch controllers.

## Interface
Parameters:
- NUM_REGIONS, 32: number of attribute regions, 1..32; bits above NUM_REGIONS-1 in area registers are read-only zero.
- REGION_SHIFT, 21: log2 of region size in bytes (21 = 2 MB).
- FAULT_DEPTH, 4: fault log entries; power of two, 2..16.
- ID_VALUE, 32'h4156_0400: value returned for CRn 0.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_fetch_stall  in  1  global stall; freezes register writes, reads, fault capture and flush requests.
- i_copro_crn  in  4  register number.
- i_copro_operation  in  2  1 = MRC read, 2 = MCR write, others no-op.
- i_copro_write_data  in  32  MCR data.
- i_fault  in  1  fault strobe; one log push per unstalled cycle.
- i_fault_status  in  8  fault status.
- i_fault_address  in  32  faulting address.
- i_lookup_address  in  32  address for attribute lookup.
- i_cache_flush_done  in  1  cache has completed flush.
- o_copro_read_data  out  32  registered MRC data.
- o_cache_enable  out  1  cache_control[0].
- o_cache_flush  out  1  flush request, held until done.
- o_copro_busy  out  1  flush in progress; core must hold further CP15 ops.
- o_lookup_cacheable / o_lookup_updateable / o_lookup_disruptive  out  1 each  registered attributes of i_lookup_address.
- o_fault_pending  out  1  fault log non-empty.

## Operation
- Registers: CRn 2 cache_control[2:0]; CRn 3 cacheable, 4 updateable, 5 disruptive, each NUM_REGIONS bits, zero-extended on read.
- MCR (op 2, unstalled): CRn 2–5 load the masked data. CRn 1 requests a flush. CRn 8 pops the fault log; if write data bit 0 = 1, it also clears the overflow flag. Other CRn are ignored.
- MRC data, updated every unstalled cycle from CRn regardless of op:
  - CRn 0: ID_VALUE.
  - CRn 1: {31'd0, busy}.
  - CRn 2–5: register contents.
  - CRn 6: {overflow, 7'd0, 8-bit count, 8'd0, head status}.
  - CRn 7: head address.
  - Others: 0. An empty log reads status and address as 0.
- Flush FSM, states IDLE and FLUSH:
  - IDLE→FLUSH on CRn 1 write.
  - FLUSH→IDLE on i_cache_flush_done.
  - o_cache_flush and o_copro_busy are high exactly in FLUSH.
  - A CRn 1 write while in FLUSH is merged and does not extend the flush.
  - A done pulse in IDLE is ignored.
- Fault log, FIFO of {status, address}:
  - Push on i_fault && !i_fetch_stall.
  - Push when full drops the entry and sets the sticky overflow flag.
  - Pop when empty is ignored.
  - Simultaneous push and pop when full: both succeed, count unchanged, overflow not set.
  - Simultaneous push and pop when empty: push only, count becomes 1.
- Lookup: idx = i_lookup_address >> REGION_SHIFT. Flags = area[idx] if idx < NUM_REGIONS, else all 0. Lookup is independent of stall.
- Reset values: all registers 0, FSM IDLE, log empty, overflow 0. Outputs: read data 0, cache_enable 0, flush 0, busy 0, lookup flags 0, fault_pending 0. Reset mid-flush drops the request immediately.

## Timing
- MCR write is visible on outputs and readable from the cycle after the write edge.
- MRC: o_copro_read_data is valid one cycle after CRn is presented.
- Flush request:
  - o_cache_flush rises one cycle after the CRn 1 write.
  - It falls one cycle after i_cache_flush_done is sampled high.
  - Minimum FLUSH duration is 1 cycle.
- Fault log:
  - A pushed fault is readable and sets o_fault_pending the following cycle.
  - A pop updates head and count the following cycle.
- Lookup latency: 1 cycle.

## Structure
- Shared package a23_copro15_pkg: CRn constants (ID, FLUSH, CTRL, CACHEABLE, UPDATEABLE, DISRUPTIVE, FSTATUS, FADDR, FPOP), operation codes (MRC=1, MCR=2), flush state encoding.
- Sub-module a23_fault_fifo: parametrised synchronous FIFO with push, pop, count, full/empty and a drop-on-full flag.

## Test plan
- Reset, then MRC CRn 0 → ID_VALUE. Write CRn 3 = 32'hFFFF_FFFF with NUM_REGIONS=8 → readback 32'h0000_00FF.
- Write CRn 1, hold done low 5 cycles → o_cache_flush and busy high for 5 cycles plus 1. A second CRn 1 write mid-flush → single flush only.
- Set cacheable=32'h2, lookup 0x0030_0000 → cacheable=1; lookup 0x0010_0000 → 0; address with idx ≥ NUM_REGIONS → 0.
- Push 5 faults (DEPTH 4) → count 4, overflow=1, head = first fault. Pop with data 1 → count 3, overflow=0.
- Full log with push and pop in the same cycle → count stays 4, newest entry accepted, overflow stays 0. Pop on empty → no change.
- Assert i_fetch_stall during a write, a fault and a CRn 1 write → no state change. Assert reset mid-flush → flush low next cycle.

Source files
------------

// File: rtl/a23_copro15_pkg.sv
`default_nettype none
// ============================================================================
// Module      : a23_copro15_pkg
// Description : Shared constants for the CP15 system-control coprocessor.
//               Holds register numbers, operation codes, the flush state
//               encoding and the region mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package a23_copro15_pkg;

  // CP15 register numbers (CRn)
  localparam logic [3:0] CRN_ID         = 4'd0;
  localparam logic [3:0] CRN_FLUSH      = 4'd1;
  localparam logic [3:0] CRN_CTRL       = 4'd2;
  localparam logic [3:0] CRN_CACHEABLE  = 4'd3;
  localparam logic [3:0] CRN_UPDATEABLE = 4'd4;
  localparam logic [3:0] CRN_DISRUPTIVE = 4'd5;
  localparam logic [3:0] CRN_FSTATUS    = 4'd6;
  localparam logic [3:0] CRN_FADDR      = 4'd7;
  localparam logic [3:0] CRN_FPOP       = 4'd8;

  // Coprocessor operation codes
  localparam logic [1:0] OP_MRC = 2'd1;
  localparam logic [1:0] OP_MCR = 2'd2;

  // Flush handshake states
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_t;

  // Mask of implemented bits in an area register
  function automatic logic [31:0] region_mask(input int num_regions);
    if (num_regions >= 32) region_mask = 32'hFFFF_FFFF;
    else                   region_mask = (32'd1 << num_regions) - 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/a23_fault_fifo.sv
`default_nettype none
// ============================================================================
// Module      : a23_fault_fifo
// Description : Synchronous FIFO for the fault log. Drops pushes when full
//               (unless a pop frees the slot in the same cycle) and records
//               the loss in a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module a23_fault_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 40
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clr_overflow,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;
  logic             drop;

  // A pop on a full log frees the slot, so a same-cycle push is accepted
  always_comb begin
    full    = (count == (AW+1)'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    drop    = push && !do_push;
    rdata   = empty ? '0 : mem[rd_ptr];
  end

  // Pointer and occupancy tracking; pointers wrap since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed since reads are gated by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Sticky loss flag; a new drop wins over a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst)               overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (clr_overflow) overflow <= 1'b0;
  end

endmodule
`default_nettype wire

// File: rtl/a23_copro15_v2.sv
`default_nettype none
// ============================================================================
// Module      : a23_copro15_v2
// Description : CP15 system-control coprocessor: cache control, per-region
//               attribute registers, registered attribute lookup, handshaked
//               cache flush and a FIFO fault log.
// Revision    : 1.0 - initial release
// ============================================================================
module a23_copro15_v2
  import a23_copro15_pkg::*;
#(
  parameter int          NUM_REGIONS  = 32,
  parameter int          REGION_SHIFT = 21,
  parameter int          FAULT_DEPTH  = 4,
  parameter logic [31:0] ID_VALUE     = 32'h4156_0400
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_fetch_stall,
  input  logic [3:0]  i_copro_crn,
  input  logic [1:0]  i_copro_operation,
  input  logic [31:0] i_copro_write_data,
  input  logic        i_fault,
  input  logic [7:0]  i_fault_status,
  input  logic [31:0] i_fault_address,
  input  logic [31:0] i_lookup_address,
  input  logic        i_cache_flush_done,
  output logic [31:0] o_copro_read_data,
  output logic        o_cache_enable,
  output logic        o_cache_flush,
  output logic        o_copro_busy,
  output logic        o_lookup_cacheable,
  output logic        o_lookup_updateable,
  output logic        o_lookup_disruptive,
  output logic        o_fault_pending
);

  localparam int          CW        = $clog2(FAULT_DEPTH) + 1;
  localparam logic [31:0] AREA_MASK = region_mask(NUM_REGIONS);

  logic [2:0]   cache_control;
  logic [31:0]  cacheable;
  logic [31:0]  updateable;
  logic [31:0]  disruptive;
  flush_state_t state;
  flush_state_t state_next;
  logic         mcr;
  logic         flush_req;
  logic         fault_pop;
  logic         fault_clr;
  logic         fault_push;
  logic [39:0]  log_head;
  logic [CW-1:0] log_count;
  logic         log_empty;
  logic         log_overflow;
  logic [31:0]  read_next;
  logic [31:0]  idx;
  logic         in_range;

  // Decode of the unstalled coprocessor write and fault strobes
  always_comb begin
    mcr        = (i_copro_operation == OP_MCR) && !i_fetch_stall;
    flush_req  = mcr && (i_copro_crn == CRN_FLUSH);
    fault_pop  = mcr && (i_copro_crn == CRN_FPOP);
    fault_clr  = fault_pop && i_copro_write_data[0];
    fault_push = i_fault && !i_fetch_stall;
  end

  // Control and area register writes; unimplemented region bits stay zero
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cache_control <= '0;
      cacheable     <= '0;
      updateable    <= '0;
      disruptive    <= '0;
    end else if (mcr) begin
      case (i_copro_crn)
        CRN_CTRL:       cache_control <= i_copro_write_data[2:0];
        CRN_CACHEABLE:  cacheable     <= i_copro_write_data & AREA_MASK;
        CRN_UPDATEABLE: updateable    <= i_copro_write_data & AREA_MASK;
        CRN_DISRUPTIVE: disruptive    <= i_copro_write_data & AREA_MASK;
        default:        ;
      endcase
    end
  end

  // Flush state register
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Flush next state; repeat requests while flushing merge into the current one
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (flush_req)          state_next = ST_FLUSH;
      ST_FLUSH: if (i_cache_flush_done) state_next = ST_IDLE;
      default:                          state_next = ST_IDLE;
    endcase
  end

  assign o_cache_flush  = (state == ST_FLUSH);
  assign o_copro_busy   = (state == ST_FLUSH);
  assign o_cache_enable = cache_control[0];

  a23_fault_fifo #(
    .DEPTH (FAULT_DEPTH),
    .WIDTH (40)
  ) u_fault_fifo (
    .clk          (i_clk),
    .rst          (i_rst),
    .push         (fault_push),
    .pop          (fault_pop),
    .clr_overflow (fault_clr),
    .wdata        ({i_fault_status, i_fault_address}),
    .rdata        (log_head),
    .count        (log_count),
    .empty        (log_empty),
    .overflow     (log_overflow)
  );

  assign o_fault_pending = !log_empty;

  // Read mux, selected by CRn independent of the operation code
  always_comb begin
    read_next = '0;
    case (i_copro_crn)
      CRN_ID:         read_next = ID_VALUE;
      CRN_FLUSH:      read_next = {31'd0, o_copro_busy};
      CRN_CTRL:       read_next = {29'd0, cache_control};
      CRN_CACHEABLE:  read_next = cacheable;
      CRN_UPDATEABLE: read_next = updateable;
      CRN_DISRUPTIVE: read_next = disruptive;
      CRN_FSTATUS:    read_next = {log_overflow, 7'd0, {(8-CW){1'b0}}, log_count,
                                   8'd0, log_head[39:32]};
      CRN_FADDR:      read_next = log_head[31:0];
      default:        read_next = '0;
    endcase
  end

  // Registered read data, frozen while the pipeline is stalled
  always_ff @(posedge i_clk) begin
    if (i_rst)               o_copro_read_data <= '0;
    else if (!i_fetch_stall) o_copro_read_data <= read_next;
  end

  always_comb begin
    idx      = i_lookup_address >> REGION_SHIFT;
    in_range = (idx < 32'(NUM_REGIONS));
  end

  // Registered attribute lookup; addresses beyond the last region get no attributes
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_lookup_cacheable  <= 1'b0;
      o_lookup_updateable <= 1'b0;
      o_lookup_disruptive <= 1'b0;
    end else begin
      o_lookup_cacheable  <= in_range && cacheable[idx[4:0]];
      o_lookup_updateable <= in_range && updateable[idx[4:0]];
      o_lookup_disruptive <= in_range && disruptive[idx[4:0]];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_a23_copro15_v2.sv
`default_nettype none
// ============================================================================
// Module      : tb_a23_copro15_v2
// Description : Directed self-checking bench for a23_copro15_v2 with
//               NUM_REGIONS=8 and FAULT_DEPTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_a23_copro15_v2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [3:0]  crn = '0;
  logic [1:0]  op = '0;
  logic [31:0] wdata = '0;
  logic        fault = 1'b0;
  logic [7:0]  fstatus = '0;
  logic [31:0] faddr = '0;
  logic [31:0] laddr = '0;
  logic        done = 1'b0;
  logic [31:0] rdata;
  logic        cache_en, flush, busy, lc, lu, ld, pending;

  int total = 0;
  int bad   = 0;

  a23_copro15_v2 #(
    .NUM_REGIONS  (8),
    .REGION_SHIFT (21),
    .FAULT_DEPTH  (4),
    .ID_VALUE     (32'h4156_0400)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_fetch_stall       (stall),
    .i_copro_crn         (crn),
    .i_copro_operation   (op),
    .i_copro_write_data  (wdata),
    .i_fault             (fault),
    .i_fault_status      (fstatus),
    .i_fault_address     (faddr),
    .i_lookup_address    (laddr),
    .i_cache_flush_done  (done),
    .o_copro_read_data   (rdata),
    .o_cache_enable      (cache_en),
    .o_cache_flush       (flush),
    .o_copro_busy        (busy),
    .o_lookup_cacheable  (lc),
    .o_lookup_updateable (lu),
    .o_lookup_disruptive (ld),
    .o_fault_pending     (pending)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mcr(input logic [3:0] c, input logic [31:0] d);
    op = 2'd2; crn = c; wdata = d;
    tick();
    op = 2'd0;
  endtask

  task automatic mrc(input logic [3:0] c, output logic [31:0] d);
    op = 2'd1; crn = c;
    tick();
    d = rdata;
    op = 2'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h want %h", rdata, 32'd0); end
    total++; if ({cache_en, flush, busy} !== 3'b000) begin bad++; $display("FAIL reset_ctrl: got %b want 000", {cache_en, flush, busy}); end
    total++; if ({lc, lu, ld, pending} !== 4'b0000) begin bad++; $display("FAIL reset_flags: got %b want 0000", {lc, lu, ld, pending}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_regs();
    logic [31:0] d;
    mrc(4'd0, d);
    total++; if (d !== 32'h4156_0400) begin bad++; $display("FAIL id: got %h want %h", d, 32'h4156_0400); end
    mrc(4'd9, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL unused_crn: got %h want 0", d); end
    mcr(4'd3, 32'hFFFF_FFFF);
    mrc(4'd3, d);
    total++; if (d !== 32'h0000_00FF) begin bad++; $display("FAIL area_mask: got %h want %h", d, 32'h0000_00FF); end
    mcr(4'd2, 32'hFFFF_FFFF);
    total++; if (cache_en !== 1'b1) begin bad++; $display("FAIL cache_enable: got %b want 1", cache_en); end
    mrc(4'd2, d);
    total++; if (d !== 32'd7) begin bad++; $display("FAIL ctrl_read: got %h want 7", d); end
    mcr(4'd2, 32'd0);
    total++; if (cache_en !== 1'b0) begin bad++; $display("FAIL cache_disable: got %b want 0", cache_en); end
  endtask

  task automatic test_flush();
    mcr(4'd1, 32'd0);
    total++; if ({flush, busy} !== 2'b11) begin bad++; $display("FAIL flush_rise: got %b want 11", {flush, busy}); end
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin op = 2'd2; crn = 4'd1; end
      if (i == 2) begin op = 2'd1; crn = 4'd1; end
      tick();
      op = 2'd0;
      total++; if ({flush, busy} !== 2'b11) begin bad++; $display("FAIL flush_hold: cycle %0d got %b want 11", i, {flush, busy}); end
      if (i == 2) begin
        total++; if (rdata !== 32'd1) begin bad++; $display("FAIL busy_read: got %h want 1", rdata); end
      end
    end
    done = 1'b1;
    #1;
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL flush_last: got %b want 1", flush); end
    tick();
    done = 1'b0;
    total++; if ({flush, busy} !== 2'b00) begin bad++; $display("FAIL flush_fall: got %b want 00", {flush, busy}); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (flush !== 1'b0) begin bad++; $display("FAIL flush_merged: cycle %0d got %b want 0", i, flush); end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    total++; if (flush !== 1'b0) begin bad++; $display("FAIL done_idle: got %b want 0", flush); end
  endtask

  task automatic test_lookup();
    mcr(4'd3, 32'h2);
    mcr(4'd4, 32'h80);
    laddr = 32'h0030_0000; tick();
    total++; if ({lc, lu, ld} !== 3'b100) begin bad++; $display("FAIL lookup_idx1: got %b want 100", {lc, lu, ld}); end
    laddr = 32'h0010_0000; tick();
    total++; if ({lc, lu, ld} !== 3'b000) begin bad++; $display("FAIL lookup_idx0: got %b want 000", {lc, lu, ld}); end
    laddr = 32'h00E0_0000; tick();
    total++; if ({lc, lu, ld} !== 3'b010) begin bad++; $display("FAIL lookup_idx7: got %b want 010", {lc, lu, ld}); end
    laddr = 32'h0100_0000; tick();
    total++; if ({lc, lu, ld} !== 3'b000) begin bad++; $display("FAIL lookup_range: got %b want 000", {lc, lu, ld}); end
  endtask

  task automatic test_fault_overflow();
    logic [31:0] d;
    for (int i = 0; i < 5; i++) begin
      fault = 1'b1; fstatus = 8'(i + 1); faddr = 32'h1000 + 32'(i);
      tick();
      fault = 1'b0;
      if (i == 0) begin
        total++; if (pending !== 1'b1) begin bad++; $display("FAIL pending_set: got %b want 1", pending); end
      end
    end
    mrc(4'd6, d);
    total++; if (d !== 32'h8004_0001) begin bad++; $display("FAIL log_overflow: got %h want %h", d, 32'h8004_0001); end
    mrc(4'd7, d);
    total++; if (d !== 32'h0000_1000) begin bad++; $display("FAIL log_head_addr: got %h want %h", d, 32'h1000); end
    mcr(4'd8, 32'd1);
    mrc(4'd6, d);
    total++; if (d !== 32'h0003_0002) begin bad++; $display("FAIL pop_clear: got %h want %h", d, 32'h0003_0002); end
    mrc(4'd7, d);
    total++; if (d !== 32'h0000_1001) begin bad++; $display("FAIL pop_addr: got %h want %h", d, 32'h1001); end
  endtask

  task automatic test_push_pop();
    logic [31:0] d;
    fault = 1'b1; fstatus = 8'h10; faddr = 32'h2000;
    tick();
    fault = 1'b0;
    mrc(4'd6, d);
    total++; if (d !== 32'h0004_0002) begin bad++; $display("FAIL refill: got %h want %h", d, 32'h0004_0002); end
    fault = 1'b1; fstatus = 8'h20; faddr = 32'h3000;
    op = 2'd2; crn = 4'd8; wdata = 32'd0;
    tick();
    fault = 1'b0; op = 2'd0;
    mrc(4'd6, d);
    total++; if (d !== 32'h0004_0003) begin bad++; $display("FAIL full_push_pop: got %h want %h", d, 32'h0004_0003); end
    mcr(4'd8, 32'd0); mcr(4'd8, 32'd0); mcr(4'd8, 32'd0);
    mrc(4'd6, d);
    total++; if (d !== 32'h0001_0020) begin bad++; $display("FAIL newest_status: got %h want %h", d, 32'h0001_0020); end
    mrc(4'd7, d);
    total++; if (d !== 32'h0000_3000) begin bad++; $display("FAIL newest_addr: got %h want %h", d, 32'h3000); end
    mcr(4'd8, 32'd0);
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL pending_clear: got %b want 0", pending); end
    mcr(4'd8, 32'd0);
    mrc(4'd6, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL pop_empty: got %h want 0", d); end
    mrc(4'd7, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL empty_addr: got %h want 0", d); end
    fault = 1'b1; fstatus = 8'h33; faddr = 32'h4444;
    op = 2'd2; crn = 4'd8; wdata = 32'd0;
    tick();
    fault = 1'b0; op = 2'd0;
    mrc(4'd6, d);
    total++; if (d !== 32'h0001_0033) begin bad++; $display("FAIL empty_push_pop: got %h want %h", d, 32'h0001_0033); end
    mcr(4'd8, 32'd0);
    total++; if (pending !== 1'b0) begin bad++; $display("FAIL drain: got %b want 0", pending); end
  endtask

  task automatic test_stall();
    logic [31:0] d;
    mrc(4'd0, d);
    stall = 1'b1;
    op = 2'd2; crn = 4'd3; wdata = 32'h55; fault = 1'b1; fstatus = 8'h77; faddr = 32'h7777;
    tick();
    crn = 4'd1;
    tick();
    stall = 1'b0; op = 2'd0; fault = 1'b0;
    total++; if (rdata !== 32'h4156_0400) begin bad++; $display("FAIL stall_read_hold: got %h want %h", rdata, 32'h4156_0400); end
    total++; if ({flush, pending} !== 2'b00) begin bad++; $display("FAIL stall_no_effect: got %b want 00", {flush, pending}); end
    mrc(4'd3, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL stall_write: got %h want 2", d); end
  endtask

  task automatic test_reset_mid_flush();
    logic [31:0] d;
    mcr(4'd1, 32'd0);
    total++; if (flush !== 1'b1) begin bad++; $display("FAIL rst_flush_start: got %b want 1", flush); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if ({flush, busy} !== 2'b00) begin bad++; $display("FAIL rst_flush_drop: got %b want 00", {flush, busy}); end
    mrc(4'd3, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_regs: got %h want 0", d); end
  endtask

  initial begin
    test_reset();
    test_regs();
    test_flush();
    test_lookup();
    test_fault_overflow();
    test_push_pop();
    test_stall();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
